// File: rtl/axil_mcl_pkt_assembler.sv
// Multi-channel AXI-Lite word to MCL request packet assembler.
// Each channel packs wpp host words, holds one finished packet and meters it out against host credits.
module axil_mcl_pkt_assembler #(
   parameter  int axil_data_width_p = 32,
   parameter  int pkt_width_p       = 128,
   parameter  int num_endpoint_p    = 2,
   parameter  int max_credits_p     = 32,
   localparam int chan_w_lp         = (num_endpoint_p > 1) ? $clog2(num_endpoint_p) : 1,
   localparam int cred_w_lp         = $clog2(max_credits_p + 1)
) (
   input  logic                                  clk_i,
   input  logic                                  reset_i,
   input  logic                                  wr_v_i,
   input  logic [chan_w_lp-1:0]                  wr_chan_i,
   input  logic [axil_data_width_p-1:0]          wr_data_i,
   output logic                                  wr_ready_o,
   input  logic [num_endpoint_p-1:0]             flush_i,
   output logic [num_endpoint_p-1:0]             pkt_v_o,
   output logic [num_endpoint_p*pkt_width_p-1:0] pkt_o,
   input  logic [num_endpoint_p-1:0]             pkt_yumi_i,
   input  logic [num_endpoint_p-1:0]             credit_return_i,
   output logic [num_endpoint_p*cred_w_lp-1:0]   credits_o,
   output logic                                  err_o
);

   localparam int wpp_lp   = pkt_width_p / axil_data_width_p;
   localparam int cnt_w_lp = $clog2(wpp_lp);
   localparam logic [cnt_w_lp-1:0]  last_cnt_lp = cnt_w_lp'(wpp_lp - 1);
   localparam logic [cred_w_lp-1:0] max_cred_lp = cred_w_lp'(max_credits_p);

   logic [cnt_w_lp-1:0]    r_cnt  [num_endpoint_p];
   logic [pkt_width_p-1:0] r_acc  [num_endpoint_p];
   logic                   r_full [num_endpoint_p];
   logic [pkt_width_p-1:0] r_pkt  [num_endpoint_p];
   logic [cred_w_lp-1:0]   r_cred [num_endpoint_p];
   logic                   r_err;

   logic [num_endpoint_p-1:0] w_sel;
   logic [num_endpoint_p-1:0] w_blk;
   logic [num_endpoint_p-1:0] w_err_set;

   // Only a channel whose last word would overwrite an unconsumed packet can stall the host.
   assign wr_ready_o = ~|(w_sel & w_blk);
   assign err_o      = r_err;

   for (genvar c = 0; c < num_endpoint_p; c++) begin : g_chan
      logic                   w_at_last;
      logic                   w_acc;
      logic                   w_last;
      logic                   w_hs;
      logic [pkt_width_p-1:0] w_new_pkt;

      assign w_sel[c]   = (wr_chan_i == chan_w_lp'(c));
      assign w_at_last  = (r_cnt[c] == last_cnt_lp);
      assign w_blk[c]   = w_at_last & r_full[c] & ~pkt_yumi_i[c];
      assign pkt_v_o[c] = r_full[c] & (r_cred[c] != '0);
      assign w_acc      = wr_v_i & wr_ready_o & w_sel[c];
      assign w_last     = w_acc & w_at_last;
      assign w_hs       = pkt_v_o[c] & pkt_yumi_i[c];
      assign w_err_set[c] = (pkt_yumi_i[c] & ~pkt_v_o[c])
                          | (credit_return_i[c] & ~w_hs & (r_cred[c] == max_cred_lp));

      assign pkt_o[c*pkt_width_p +: pkt_width_p]   = r_pkt[c];
      assign credits_o[c*cred_w_lp +: cred_w_lp]   = r_cred[c];

      always_comb begin
         w_new_pkt = r_acc[c];
         w_new_pkt[pkt_width_p-1 -: axil_data_width_p] = wr_data_i;
      end

      // A last word completes the packet even under flush; otherwise flush drops the word.
      always_ff @(posedge clk_i or posedge reset_i) begin
         if (reset_i) begin
            r_cnt[c] <= '0;
            r_acc[c] <= '0;
         end else if (w_last || flush_i[c]) begin
            r_cnt[c] <= '0;
            r_acc[c] <= '0;
         end else if (w_acc) begin
            r_acc[c][r_cnt[c]*axil_data_width_p +: axil_data_width_p] <= wr_data_i;
            r_cnt[c] <= r_cnt[c] + cnt_w_lp'(1);
         end else begin
            r_cnt[c] <= r_cnt[c];
            r_acc[c] <= r_acc[c];
         end
      end

      always_ff @(posedge clk_i or posedge reset_i) begin
         if (reset_i) begin
            r_full[c] <= 1'b0;
            r_pkt[c]  <= '0;
         end else if (w_last) begin
            r_full[c] <= 1'b1;
            r_pkt[c]  <= w_new_pkt;
         end else if (w_hs) begin
            r_full[c] <= 1'b0;
         end else begin
            r_full[c] <= r_full[c];
         end
      end

      // Return and consume in one cycle cancel; a return at the ceiling is dropped.
      always_ff @(posedge clk_i or posedge reset_i) begin
         if (reset_i) begin
            r_cred[c] <= max_cred_lp;
         end else if (w_hs && !credit_return_i[c]) begin
            r_cred[c] <= r_cred[c] - cred_w_lp'(1);
         end else if (credit_return_i[c] && !w_hs && (r_cred[c] != max_cred_lp)) begin
            r_cred[c] <= r_cred[c] + cred_w_lp'(1);
         end else begin
            r_cred[c] <= r_cred[c];
         end
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_err <= 1'b0;
      end else if (|w_err_set) begin
         r_err <= 1'b1;
      end else begin
         r_err <= r_err;
      end
   end

endmodule

// File: tb/tb_axil_mcl_pkt_assembler.sv
// Directed bench for axil_mcl_pkt_assembler with a per-channel packet scoreboard.
module tb_axil_mcl_pkt_assembler;

   logic         clk = 1'b0;
   logic         reset_i;
   logic         wr_v_i;
   logic [0:0]   wr_chan_i;
   logic [31:0]  wr_data_i;
   logic         wr_ready_o;
   logic [1:0]   flush_i;
   logic [1:0]   pkt_v_o;
   logic [255:0] pkt_o;
   logic [1:0]   pkt_yumi_i;
   logic [1:0]   credit_return_i;
   logic [11:0]  credits_o;
   logic         err_o;

   int n_chk  = 0;
   int n_fail = 0;

   logic [127:0] q0[$];
   logic [127:0] q1[$];
   logic [127:0] m_acc [2];
   int           m_cnt [2];
   int           m_cred[2];

   axil_mcl_pkt_assembler dut (
      .clk_i(clk), .reset_i(reset_i), .wr_v_i(wr_v_i), .wr_chan_i(wr_chan_i),
      .wr_data_i(wr_data_i), .wr_ready_o(wr_ready_o), .flush_i(flush_i),
      .pkt_v_o(pkt_v_o), .pkt_o(pkt_o), .pkt_yumi_i(pkt_yumi_i),
      .credit_return_i(credit_return_i), .credits_o(credits_o), .err_o(err_o)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q0.delete();
      q1.delete();
      for (int ch = 0; ch < 2; ch++) begin
         m_acc[ch]  = '0;
         m_cnt[ch]  = 0;
         m_cred[ch] = 32;
      end
   endtask

   task automatic model_word(input int c, input logic [31:0] d, input logic [1:0] fl);
      logic [127:0] p;
      for (int ch = 0; ch < 2; ch++) begin
         if (ch == c && m_cnt[ch] == 3) begin
            p = m_acc[ch];
            p[127:96] = d;
            if (ch == 0) q0.push_back(p); else q1.push_back(p);
            m_acc[ch] = '0;
            m_cnt[ch] = 0;
         end else if (fl[ch]) begin
            m_acc[ch] = '0;
            m_cnt[ch] = 0;
         end else if (ch == c) begin
            m_acc[ch][m_cnt[ch]*32 +: 32] = d;
            m_cnt[ch]++;
         end
      end
   endtask

   task automatic send(input int c, input logic [31:0] d, input logic [1:0] fl);
      wr_v_i    = 1'b1;
      wr_chan_i = c[0:0];
      wr_data_i = d;
      flush_i   = fl;
      tick();
      wr_v_i  = 1'b0;
      flush_i = 2'b00;
      model_word(c, d, fl);
   endtask

   task automatic send_pkt(input int c, input logic [31:0] base);
      for (int k = 0; k < 4; k++) send(c, base + 32'(k), 2'b00);
   endtask

   task automatic pop_check(input int c);
      logic [127:0] e;
      int i;
      i = 0;
      while (pkt_v_o[c] !== 1'b1 && i < 40) begin
         tick();
         i++;
      end
      chk("pkt_v_wait", {127'd0, pkt_v_o[c]}, 128'd1);
      e = 'x;
      if (c == 0 && q0.size() > 0) e = q0.pop_front();
      if (c == 1 && q1.size() > 0) e = q1.pop_front();
      chk("pkt_data", pkt_o[c*128 +: 128], e);
      pkt_yumi_i[c] = 1'b1;
      tick();
      pkt_yumi_i[c] = 1'b0;
      m_cred[c]--;
      chk("credits_after_yumi", {122'd0, credits_o[c*6 +: 6]}, 128'(m_cred[c]));
   endtask

   initial begin
      reset_i = 1'b1; wr_v_i = 1'b0; wr_chan_i = 1'b0; wr_data_i = 32'd0;
      flush_i = 2'b00; pkt_yumi_i = 2'b00; credit_return_i = 2'b00;
      model_reset();
      #12;
      chk("rst_pkt_v", {126'd0, pkt_v_o}, 128'd0);
      chk("rst_pkt_o", pkt_o[127:0] | pkt_o[255:128], 128'd0);
      chk("rst_credits", {116'd0, credits_o}, {116'd0, 6'd32, 6'd32});
      chk("rst_err", {127'd0, err_o}, 128'd0);
      reset_i = 1'b0;
      tick();
      chk("ready_after_rst", {127'd0, wr_ready_o}, 128'd1);

      // 1: basic packing and credit consumption
      send(0, 32'h11, 2'b00); send(0, 32'h22, 2'b00);
      send(0, 32'h33, 2'b00); send(0, 32'h44, 2'b00);
      chk("t1_valid_latency", {127'd0, pkt_v_o[0]}, 128'd1);
      chk("t1_packet_const", pkt_o[127:0], 128'h00000044_00000033_00000022_00000011);
      pop_check(0);
      chk("t1_valid_cleared", {127'd0, pkt_v_o[0]}, 128'd0);

      // 2: backpressure on last word, then yumi in the same cycle as the last word
      send_pkt(0, 32'h2000);
      send(0, 32'h3000, 2'b00); send(0, 32'h3001, 2'b00); send(0, 32'h3002, 2'b00);
      wr_v_i = 1'b1; wr_chan_i = 1'b0; wr_data_i = 32'h3003;
      #1;
      chk("t2_ready_low", {127'd0, wr_ready_o}, 128'd0);
      tick();
      chk("t2_ready_still_low", {127'd0, wr_ready_o}, 128'd0);
      wr_chan_i = 1'b1;
      #1;
      chk("t2_ch1_ready", {127'd0, wr_ready_o}, 128'd1);
      wr_chan_i = 1'b0;
      pkt_yumi_i[0] = 1'b1;
      #1;
      chk("t2_ready_with_yumi", {127'd0, wr_ready_o}, 128'd1);
      chk("t2_first_pkt", pkt_o[127:0], q0.pop_front());
      tick();
      wr_v_i = 1'b0; pkt_yumi_i[0] = 1'b0;
      m_cred[0]--;
      model_word(0, 32'h3003, 2'b00);
      chk("t2_second_presented", {127'd0, pkt_v_o[0]}, 128'd1);
      pop_check(0);

      // 3: drain all credits, then a held packet released by one return
      for (int k = 0; k < 29; k++) begin
         send_pkt(0, 32'h1000_0000 + 32'(k * 16));
         pop_check(0);
      end
      send_pkt(0, 32'h5000);
      tick();
      chk("t3_held", {127'd0, pkt_v_o[0]}, 128'd0);
      chk("t3_zero_credits", {122'd0, credits_o[5:0]}, 128'd0);
      credit_return_i[0] = 1'b1;
      tick();
      credit_return_i[0] = 1'b0;
      m_cred[0]++;
      chk("t3_released", {127'd0, pkt_v_o[0]}, 128'd1);
      pop_check(0);
      credit_return_i[0] = 1'b1;
      for (int k = 0; k < 32; k++) tick();
      credit_return_i[0] = 1'b0;
      m_cred[0] = 32;
      chk("t3_refilled", {122'd0, credits_o[5:0]}, 128'd32);
      chk("t3_no_err", {127'd0, err_o}, 128'd0);

      // 4: return with yumi nets zero; return at the ceiling sets sticky err
      send_pkt(0, 32'h6000);
      chk("t4_valid", {127'd0, pkt_v_o[0]}, 128'd1);
      chk("t4_pkt", pkt_o[127:0], q0.pop_front());
      pkt_yumi_i[0] = 1'b1; credit_return_i[0] = 1'b1;
      tick();
      pkt_yumi_i[0] = 1'b0;
      chk("t4_net_zero", {122'd0, credits_o[5:0]}, 128'd32);
      chk("t4_err_clear", {127'd0, err_o}, 128'd0);
      tick();
      credit_return_i[0] = 1'b0;
      chk("t4_ceiling", {122'd0, credits_o[5:0]}, 128'd32);
      chk("t4_err_set", {127'd0, err_o}, 128'd1);
      tick(); tick();
      chk("t4_err_sticky", {127'd0, err_o}, 128'd1);

      // 5: flush on ch0 interleaved with ch1 traffic
      send(1, 32'hB0, 2'b00); send(0, 32'hA0, 2'b00);
      send(1, 32'hB1, 2'b00); send(0, 32'hA1, 2'b00);
      send(0, 32'hDEAD, 2'b01);
      send(1, 32'hB2, 2'b00); send(0, 32'hC0, 2'b00);
      send(0, 32'hC1, 2'b00); send(1, 32'hB3, 2'b00);
      send(0, 32'hC2, 2'b00); send(0, 32'hC3, 2'b00);
      chk("t5_ch0_const", pkt_o[127:0], 128'h000000C3_000000C2_000000C1_000000C0);
      pop_check(1);
      pop_check(0);
      send(1, 32'hE0, 2'b00); send(1, 32'hE1, 2'b00); send(1, 32'hE2, 2'b00);
      send(1, 32'hE3, 2'b10);
      pop_check(1);
      send_pkt(1, 32'h7700);
      pop_check(1);

      // 6: async reset mid-packet with a held packet
      send_pkt(1, 32'h8800);
      send(0, 32'hF0, 2'b00); send(0, 32'hF1, 2'b00);
      #2 reset_i = 1'b1;
      #1;
      chk("t6_rst_pkt_v", {126'd0, pkt_v_o}, 128'd0);
      chk("t6_rst_pkt_o", pkt_o[127:0] | pkt_o[255:128], 128'd0);
      chk("t6_rst_credits", {116'd0, credits_o}, {116'd0, 6'd32, 6'd32});
      chk("t6_rst_err", {127'd0, err_o}, 128'd0);
      model_reset();
      #3 reset_i = 1'b0;
      tick();
      send(0, 32'h91, 2'b00); send(0, 32'h92, 2'b00);
      send(0, 32'h93, 2'b00); send(0, 32'h94, 2'b00);
      chk("t6_fresh_const", pkt_o[127:0], 128'h00000094_00000093_00000092_00000091);
      pop_check(0);
      pkt_yumi_i[1] = 1'b1;
      tick();
      pkt_yumi_i[1] = 1'b0;
      chk("t6_bad_yumi_err", {127'd0, err_o}, 128'd1);
      chk("t6_bad_yumi_credits", {122'd0, credits_o[11:6]}, 128'd32);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
